lcd1602_sequencer: RTL and testbench

//  HD44780/LCD1602 write-cycle controller for the Z80 board, replacing CPU-timed bit-banging of lcd_e/lcd_rs.

---
 rtl/lcd1602_sequencer.sv | 165 ++++++++++++++++
 tb/tb_lcd1602_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/lcd1602_sequencer.sv
// HD44780/LCD1602 write sequencer: power-on 8-bit init, then one command/data byte per
// valid/ready handshake, with setup, E-pulse, hold and execution-delay timing.
module lcd1602_sequencer #(
    parameter int T_SETUP = 2,
    parameter int T_EPW   = 12,
    parameter int T_HOLD  = 2,
    parameter int T_CMD   = 888,
    parameter int T_LONG  = 36480,
    parameter int T_PWRUP = 360000,
    parameter int T_INIT1 = 98400,
    parameter int T_INIT2 = 2400,
    parameter int CNT_W   = 19
) (
    input  logic       in_clock,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic       busy,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_d
);

    localparam logic [2:0] S_PWRUP = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_SETUP = 3'd2;
    localparam logic [2:0] S_EHIGH = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_DELAY = 3'd5;

    localparam logic [CNT_W-1:0] C_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] C_EPW   = CNT_W'(T_EPW - 1);
    localparam logic [CNT_W-1:0] C_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] C_CMD   = CNT_W'(T_CMD - 1);
    localparam logic [CNT_W-1:0] C_LONG  = CNT_W'(T_LONG - 1);
    localparam logic [CNT_W-1:0] C_PWRUP = CNT_W'(T_PWRUP - 1);
    localparam logic [CNT_W-1:0] C_INIT1 = CNT_W'(T_INIT1 - 1);
    localparam logic [CNT_W-1:0] C_INIT2 = CNT_W'(T_INIT2 - 1);

    function automatic logic [7:0] init_byte(input logic [2:0] step);
        case (step)
            3'd0, 3'd1, 3'd2: init_byte = 8'h30;
            3'd3:             init_byte = 8'h38;
            3'd4:             init_byte = 8'h08;
            3'd5:             init_byte = 8'h01;
            3'd6:             init_byte = 8'h06;
            default:          init_byte = 8'h0C;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] init_delay(input logic [2:0] step);
        case (step)
            3'd0:    init_delay = C_INIT1;
            3'd1:    init_delay = C_INIT2;
            3'd5:    init_delay = C_LONG;
            default: init_delay = C_CMD;
        endcase
    endfunction

    logic [2:0]       state_q, state_d;
    logic [2:0]       step_q, step_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rs_q, rs_d;
    logic [7:0]       d_q, d_d;
    logic             done_q, done_d;
    logic             last;
    logic [CNT_W-1:0] delay_m1;

    assign last = (cnt_q == '0);

    // Clear (0x01) and home (0x02/0x03) need the long execution time; 0x00 is treated as clear.
    always_comb begin
        if (!done_q)
            delay_m1 = init_delay(step_q);
        else if (!rs_q && d_q[7:2] == 6'b000000)
            delay_m1 = C_LONG;
        else
            delay_m1 = C_CMD;
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = last ? cnt_q : cnt_q - CNT_W'(1);
        rs_d    = rs_q;
        d_d     = d_q;
        done_d  = done_q;
        case (state_q)
            S_PWRUP: if (last) begin
                state_d = S_SETUP;
                cnt_d   = C_SETUP;
                step_d  = 3'd0;
                rs_d    = 1'b0;
                d_d     = init_byte(3'd0);
            end
            S_IDLE: if (req_valid) begin
                state_d = S_SETUP;
                cnt_d   = C_SETUP;
                rs_d    = req_rs;
                d_d     = req_data;
            end
            S_SETUP: if (last) begin
                state_d = S_EHIGH;
                cnt_d   = C_EPW;
            end
            S_EHIGH: if (last) begin
                state_d = S_HOLD;
                cnt_d   = C_HOLD;
            end
            S_HOLD: if (last) begin
                state_d = S_DELAY;
                cnt_d   = delay_m1;
            end
            S_DELAY: if (last) begin
                if (done_q) begin
                    state_d = S_IDLE;
                end else if (step_q == 3'd7) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_SETUP;
                    cnt_d   = C_SETUP;
                    step_d  = step_q + 3'd1;
                    rs_d    = 1'b0;
                    d_d     = init_byte(step_q + 3'd1);
                end
            end
            default: begin
                state_d = S_PWRUP;
                cnt_d   = C_PWRUP;
            end
        endcase
    end

    always_ff @(posedge in_clock) begin
        if (rst) begin
            state_q <= S_PWRUP;
            step_q  <= 3'd0;
            cnt_q   <= C_PWRUP;
            rs_q    <= 1'b0;
            d_q     <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            d_q     <= d_d;
            done_q  <= done_d;
        end
    end

    assign lcd_e     = (state_q == S_EHIGH);
    assign lcd_rs    = rs_q;
    assign lcd_d     = d_q;
    assign lcd_rw    = 1'b0;
    assign req_ready = (state_q == S_IDLE);
    assign busy      = ~req_ready;
    assign init_done = done_q;

endmodule

// File: tb/tb_lcd1602_sequencer.sv
// Directed bench for lcd1602_sequencer with shortened timing: every output is checked
// cycle by cycle against a table of expected byte/delay records.
module tb_lcd1602_sequencer;

    localparam int T_SETUP = 1;
    localparam int T_EPW   = 2;
    localparam int T_HOLD  = 1;
    localparam int T_CMD   = 4;
    localparam int T_LONG  = 10;
    localparam int T_PWRUP = 5;
    localparam int T_INIT1 = 8;
    localparam int T_INIT2 = 6;

    logic       in_clock = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_rs;
    logic [7:0] req_data;
    logic       req_ready;
    logic       init_done;
    logic       busy;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_d;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         dly;
    } vec_t;

    vec_t init_tab[8];
    vec_t user_tab[6];

    lcd1602_sequencer #(
        .T_SETUP(T_SETUP), .T_EPW(T_EPW), .T_HOLD(T_HOLD), .T_CMD(T_CMD),
        .T_LONG(T_LONG), .T_PWRUP(T_PWRUP), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2),
        .CNT_W(19)
    ) dut (
        .in_clock (in_clock),
        .rst      (rst),
        .req_valid(req_valid),
        .req_rs   (req_rs),
        .req_data (req_data),
        .req_ready(req_ready),
        .init_done(init_done),
        .busy     (busy),
        .lcd_e    (lcd_e),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_d    (lcd_d)
    );

    always #5 in_clock = ~in_clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(negedge in_clock);
    endtask

    task automatic cmp(input string name, input logic e, input logic rs,
                       input logic [7:0] d, input logic rdy, input logic done);
        logic [13:0] exp_v;
        logic [13:0] act_v;
        exp_v = {e, rs, d, rdy, ~rdy, done, 1'b0};
        act_v = {lcd_e, lcd_rs, lcd_d, req_ready, busy, init_done, lcd_rw};
        n_total++;
        if (act_v === exp_v)
            n_pass++;
        else
            $display("FAIL %s @%0t: got %h expected %h (e,rs,d,ready,busy,done,rw)",
                     name, $time, act_v, exp_v);
    endtask

    // One full write: SETUP, E high, hold, execution delay; user writes drop valid and
    // scramble the request inputs mid-pulse to show the latched byte is what reaches the pins.
    task automatic check_write(input vec_t v, input logic user, input logic done);
        tick;
        cmp("setup", 1'b0, v.rs, v.data, 1'b0, done);
        if (user) req_valid = 1'b0;
        for (int i = 0; i < T_EPW; i++) begin
            tick;
            cmp("ehigh", 1'b1, v.rs, v.data, 1'b0, done);
            if (user && i == 0) begin
                req_data = v.data ^ 8'hA5;
                req_rs   = ~v.rs;
            end
        end
        for (int i = 0; i < T_HOLD; i++) begin
            tick;
            cmp("hold", 1'b0, v.rs, v.data, 1'b0, done);
        end
        for (int i = 0; i < v.dly; i++) begin
            tick;
            cmp("delay", 1'b0, v.rs, v.data, 1'b0, done);
        end
    endtask

    // Caller has already checked the first power-up cycle (the reset state).
    task automatic run_init;
        for (int i = 0; i < T_PWRUP - 1; i++) begin
            tick;
            cmp("pwrup", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        end
        for (int s = 0; s < 8; s++)
            check_write(init_tab[s], 1'b0, 1'b0);
        tick;
        cmp("idle_after_init", 1'b0, 1'b0, 8'h0C, 1'b1, 1'b1);
    endtask

    initial begin
        init_tab[0] = '{1'b0, 8'h30, T_INIT1};
        init_tab[1] = '{1'b0, 8'h30, T_INIT2};
        init_tab[2] = '{1'b0, 8'h30, T_CMD};
        init_tab[3] = '{1'b0, 8'h38, T_CMD};
        init_tab[4] = '{1'b0, 8'h08, T_CMD};
        init_tab[5] = '{1'b0, 8'h01, T_LONG};
        init_tab[6] = '{1'b0, 8'h06, T_CMD};
        init_tab[7] = '{1'b0, 8'h0C, T_CMD};

        user_tab[0] = '{1'b0, 8'h01, T_LONG};
        user_tab[1] = '{1'b0, 8'h02, T_LONG};
        user_tab[2] = '{1'b0, 8'h80, T_CMD};
        user_tab[3] = '{1'b1, 8'h01, T_CMD};
        user_tab[4] = '{1'b0, 8'h00, T_LONG};
        user_tab[5] = '{1'b0, 8'h04, T_CMD};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_rs    = 1'b0;
        req_data  = 8'h00;
        repeat (3) @(posedge in_clock);
        tick;
        cmp("reset", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;

        // Request held through the whole init: must not produce an extra pulse.
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h41;
        run_init();

        // Accepted on the first idle cycle; ready returns 9 cycles later.
        check_write('{1'b1, 8'h41, T_CMD}, 1'b1, 1'b1);
        tick;
        cmp("ready_after_data", 1'b0, 1'b1, 8'h41, 1'b1, 1'b1);
        tick;
        cmp("idle_hold", 1'b0, 1'b1, 8'h41, 1'b1, 1'b1);

        for (int k = 0; k < 6; k++) begin
            req_valid = 1'b1;
            req_rs    = user_tab[k].rs;
            req_data  = user_tab[k].data;
            check_write(user_tab[k], 1'b1, 1'b1);
            tick;
            cmp("user_idle", 1'b0, user_tab[k].rs, user_tab[k].data, 1'b1, 1'b1);
        end

        // Reset pulse while E is high during a data write.
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h55;
        tick;
        cmp("mid_setup", 1'b0, 1'b1, 8'h55, 1'b0, 1'b1);
        req_valid = 1'b0;
        tick;
        cmp("mid_ehigh", 1'b1, 1'b1, 8'h55, 1'b0, 1'b1);
        rst = 1'b1;
        tick;
        cmp("reset_mid", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        run_init();
        tick;
        cmp("final_idle", 1'b0, 1'b0, 8'h0C, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
